// File: rtl/instr_encode_loader.sv
// instr_encode_loader
//   Program loader for the multi-cycle processor. Accepts decoded
//   instructions (ID + three 32-bit parameters) over a valid/ready
//   handshake, encodes each into a 32-bit R/I/J word and writes it into
//   instruction memory at consecutive addresses starting at BASE_ADDR.
//   Illegal IDs, out-of-range operands and memory overflow are flagged
//   on err_code and park the loader in ERR until the next start.
//
// Parameters:
//   ADDR_W     instruction memory address width (capacity 2^ADDR_W words)
//   BASE_ADDR  first write address of a load session
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           begins a load session, clears count and err_code
//   in_valid/ready  instruction handshake (ready == state LOAD)
//   in_id           instruction ID 1..26
//   in_rs/rt/rd     decoded parameters
//   in_last         accepted instruction ends the session
//   mem_we/addr/wdata  registered instruction memory write port
//   busy, done      state LOAD / state DONE
//   err_code        0 none, 1 bad ID, 2 operand range, 3 memory full
//   count           words written in the current session
module instr_encode_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_id,
  input  logic [31:0]       in_rs,
  input  logic [31:0]       in_rt,
  input  logic [31:0]       in_rd,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]  state;
  logic        accept;
  logic        full;
  logic [31:0] enc_word;
  logic        id_bad;
  logic        range_bad;

  // Operand range flags, shared by every format that uses the operand.
  logic rs_bad, rt_bad, rd_bad, imm_bad, jmp_bad;
  logic [5:0] id6;

  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD);
  assign done     = (state == DONE);
  assign accept   = in_valid & in_ready;
  assign full     = (count == CAPACITY);

  assign id6     = in_id[5:0];
  assign rs_bad  = |in_rs[31:5];
  assign rt_bad  = |in_rt[31:5];
  assign rd_bad  = |in_rd[31:5];
  // Immediate fits in 16 signed bits only when bits 31..15 all agree.
  assign imm_bad = ~((&in_rt[31:15]) | ~(|in_rt[31:15]));
  assign jmp_bad = |in_rs[31:26];

  // Encoder: picks the word layout and the operand checks by ID group.
  always_comb begin
    enc_word  = 32'd0;
    id_bad    = 1'b0;
    range_bad = 1'b0;
    case (in_id)
      32'd1, 32'd2, 32'd3, 32'd4: begin
        enc_word  = {6'd0, in_rs[4:0], in_rt[4:0], in_rd[4:0], 5'd0, id6 - 6'd1};
        range_bad = rs_bad | rt_bad | rd_bad;
      end
      32'd7: begin
        enc_word  = {6'd3, in_rs[4:0], in_rt[4:0], in_rd[4:0], 11'd0};
        range_bad = rs_bad | rt_bad | rd_bad;
      end
      32'd8: begin
        enc_word  = {6'd4, in_rs[4:0], in_rt[4:0], in_rd[4:0], 11'd0};
        range_bad = rs_bad | rt_bad | rd_bad;
      end
      32'd24: begin
        enc_word  = {6'd19, in_rs[4:0], in_rt[4:0], in_rd[4:0], 11'd0};
        range_bad = rs_bad | rt_bad | rd_bad;
      end
      32'd5, 32'd6, 32'd9, 32'd10: begin
        enc_word  = {id6 - 6'd4, in_rs[4:0], in_rd[4:0], in_rt[15:0]};
        range_bad = rs_bad | rd_bad | imm_bad;
      end
      32'd13, 32'd14, 32'd15, 32'd16, 32'd17, 32'd18, 32'd19, 32'd20, 32'd25: begin
        enc_word  = {id6 - 6'd5, in_rs[4:0], in_rd[4:0], in_rt[15:0]};
        range_bad = rs_bad | rd_bad | imm_bad;
      end
      32'd11, 32'd12: begin
        // Shifts: in_rt is the shift amount, so it is range-checked as a register field.
        enc_word  = {6'd7, in_rs[4:0], in_rd[4:0], 5'd0, in_rt[4:0], id6 - 6'd11};
        range_bad = rs_bad | rd_bad | rt_bad;
      end
      32'd21, 32'd22, 32'd23: begin
        enc_word  = {id6 - 6'd5, in_rs[25:0]};
        range_bad = jmp_bad;
      end
      32'd26: begin
        enc_word  = {6'd21, 26'd0};
      end
      default: begin
        id_bad = 1'b1;
      end
    endcase
  end

  // Session FSM and registered write port. start outranks any handshake in
  // the same cycle; an erroring instruction is never written. Error
  // priority is memory full, then bad ID, then operand range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      err_code  <= 2'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      mem_we <= 1'b0;
      if (start) begin
        state    <= LOAD;
        count    <= '0;
        err_code <= 2'd0;
      end else if (accept) begin
        if (full) begin
          err_code <= 2'd3;
          state    <= ERR;
        end else if (id_bad) begin
          err_code <= 2'd1;
          state    <= ERR;
        end else if (range_bad) begin
          err_code <= 2'd2;
          state    <= ERR;
        end else begin
          mem_we    <= 1'b1;
          mem_addr  <= BASE + count[ADDR_W-1:0];
          mem_wdata <= enc_word;
          count     <= count + (ADDR_W+1)'(1);
          if (in_last) begin
            state <= DONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// tb_instr_encode_loader
//   Directed bench for instr_encode_loader. A default-size instance runs
//   the encoding, handshake, error and reset scenarios; a second instance
//   with ADDR_W=2 sees the same stimulus and is used for overflow.
module tb_instr_encode_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [31:0] in_id;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic [31:0] in_rd;
  logic        in_last;

  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;
  logic [8:0]  count;

  logic        s_in_ready;
  logic        s_mem_we;
  logic [1:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic        s_busy;
  logic        s_done;
  logic [1:0]  s_err_code;
  logic [2:0]  s_count;

  int vectors;
  int miscompares;

  instr_encode_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_id(in_id), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err_code(err_code), .count(count)
  );

  instr_encode_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_id(in_id), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_last(in_last),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .busy(s_busy), .done(s_done), .err_code(s_err_code), .count(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one instruction (or an idle slot when v is 0).
  task automatic applyStimulus(input logic v, input logic [31:0] id, input logic [31:0] rs,
                               input logic [31:0] rt, input logic [31:0] rd, input logic last);
    in_valid = v;
    in_id    = id;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_last  = last;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    start       = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    tick();
    tick();

    // Reset state
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_busy_done", 32'({busy, done}), 32'd0);
    checkOutput("rst_err_count", 32'({err_code, count}), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 32'd1, 32'd1, 32'd2, 32'd3, 1'b0);
    tick();
    checkOutput("idle_no_accept", 32'({in_ready, mem_we}), 32'd0);

    // Single R-type
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("load_ready_busy", 32'({in_ready, busy, done}), 32'b110);
    applyStimulus(1'b1, 32'd1, 32'd1, 32'd2, 32'd3, 1'b0);
    tick();
    checkOutput("r_we", 32'(mem_we), 32'd1);
    checkOutput("r_addr", 32'(mem_addr), 32'd0);
    checkOutput("r_wdata", mem_wdata, 32'h00221800);
    checkOutput("r_count", 32'(count), 32'd1);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    tick();
    checkOutput("r_we_drop", 32'(mem_we), 32'd0);
    checkOutput("r_wdata_hold", mem_wdata, 32'h00221800);

    // A few more formats in the same session
    applyStimulus(1'b1, 32'd12, 32'd3, 32'd31, 32'd4, 1'b0);
    tick();
    checkOutput("srl_wdata", mem_wdata, 32'h1C6407C1);
    checkOutput("srl_addr", 32'(mem_addr), 32'd1);
    applyStimulus(1'b1, 32'd24, 32'd5, 32'd6, 32'd7, 1'b0);
    tick();
    checkOutput("id24_wdata", mem_wdata, 32'h4CA63800);
    applyStimulus(1'b1, 32'd4, 32'd0, 32'd0, 32'd31, 1'b0);
    tick();
    checkOutput("id4_wdata", mem_wdata, 32'h0000F803);
    applyStimulus(1'b1, 32'd26, 32'd7, 32'd7, 32'd7, 1'b0);
    tick();
    checkOutput("id26_wdata", mem_wdata, 32'h54000000);
    checkOutput("five_count", 32'(count), 32'd5);

    // start has priority over a same-cycle handshake
    start = 1'b1;
    applyStimulus(1'b1, 32'd1, 32'd1, 32'd2, 32'd3, 1'b0);
    tick();
    start = 1'b0;
    checkOutput("start_prio_we", 32'(mem_we), 32'd0);
    checkOutput("start_prio_count", 32'(count), 32'd0);

    // Burst with last
    applyStimulus(1'b1, 32'd5, 32'd4, 32'hFFFFFFFF, 32'd5, 1'b0);
    tick();
    checkOutput("b0_we_addr", 32'({mem_we, mem_addr}), {23'd0, 1'b1, 8'd0});
    checkOutput("b0_wdata", mem_wdata, 32'h0485FFFF);
    applyStimulus(1'b1, 32'd11, 32'd1, 32'd10, 32'd2, 1'b0);
    tick();
    checkOutput("b1_we_addr", 32'({mem_we, mem_addr}), {23'd0, 1'b1, 8'd1});
    checkOutput("b1_wdata", mem_wdata, 32'h1C220280);
    applyStimulus(1'b1, 32'd21, 32'd100, 32'd0, 32'd0, 1'b1);
    tick();
    checkOutput("b2_we_addr", 32'({mem_we, mem_addr}), {23'd0, 1'b1, 8'd2});
    checkOutput("b2_wdata", mem_wdata, 32'h40000064);
    checkOutput("b2_done_ready_busy", 32'({done, in_ready, busy}), 32'b100);
    checkOutput("b2_count", 32'(count), 32'd3);
    tick();
    checkOutput("done_hold", 32'({done, mem_we}), 32'b10);

    // Bad ID
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus(1'b1, 32'd27, 32'd0, 32'd0, 32'd0, 1'b0);
    tick();
    checkOutput("badid_err", 32'(err_code), 32'd1);
    checkOutput("badid_we_ready", 32'({mem_we, in_ready}), 32'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("restart_err", 32'(err_code), 32'd0);
    checkOutput("restart_ready", 32'(in_ready), 32'd1);

    // Operand out of range
    applyStimulus(1'b1, 32'd5, 32'd0, 32'h00010000, 32'd0, 1'b0);
    tick();
    checkOutput("imm_range_err", 32'({err_code, mem_we}), 32'b100);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus(1'b1, 32'd1, 32'd0, 32'd0, 32'd32, 1'b1);
    tick();
    checkOutput("rd_range_err", 32'({err_code, mem_we}), 32'b100);
    checkOutput("err_ignores_last", 32'({done, count}), 32'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus(1'b1, 32'd22, 32'h04000000, 32'd0, 32'd0, 1'b0);
    tick();
    checkOutput("jmp_range_err", 32'(err_code), 32'd2);

    // Overflow on the ADDR_W=2 instance
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus(1'b1, 32'd26, 32'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("ovf_write", 32'({s_mem_we, s_mem_addr, s_count}), 32'({1'b1, 2'(i), 3'(i + 1)}));
    end
    tick();
    checkOutput("ovf_err", 32'(s_err_code), 32'd3);
    checkOutput("ovf_count_we", 32'({s_count, s_mem_we, s_in_ready}), 32'({3'd4, 1'b0, 1'b0}));

    // Reset mid-burst
    start = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    tick();
    start = 1'b0;
    applyStimulus(1'b1, 32'd1, 32'd1, 32'd2, 32'd3, 1'b0);
    tick();
    checkOutput("pre_rst_we", 32'(mem_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_we_ready", 32'({mem_we, in_ready, busy, done}), 32'd0);
    checkOutput("async_rst_count", 32'({err_code, count, mem_addr}), 32'd0);
    checkOutput("async_rst_wdata", mem_wdata, 32'd0);
    #2;
    rst = 1'b0;
    tick();
    checkOutput("post_rst_idle", 32'({in_ready, mem_we, count}), 32'd0);
    start = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    tick();
    start = 1'b0;
    checkOutput("post_rst_start", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_encode_loader.md
# instr_encode_loader

Program loader for the multi-cycle processor. It accepts decoded instructions (instruction ID plus three 32-bit parameters, the same form the instruction decoder produces) over a valid/ready handshake. It encodes each one into the 32-bit R/I/J instruction word and writes the word into instruction memory at consecutive addresses. It sits between the testbench or host stimulus and the instruction memory write port, and flags illegal IDs, out-of-range operands and memory overflow.

## Interface
- `ADDR_W`, default 8: instruction memory address width; capacity is 2^ADDR_W words.
- `BASE_ADDR`, default 0: first write address of a load session.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; **asynchronous, active-high**.
- `start`  in  1  pulse that begins a load session; clears `count` and `err_code`.
- `in_valid`  in  1  instruction present on `in_*`.
- `in_ready`  out  1  loader can accept an instruction.
- `in_id`  in  32  instruction ID, 1–26.
- `in_rs`, `in_rt`, `in_rd`  in  32 each  parameters, with the same meaning as the decoder outputs.
- `in_last`  in  1  the accepted instruction is the final one of the session.
- `mem_we`  out  1  write strobe, one cycle per word.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  32  encoded word.
- `busy`  out  1  high in state LOAD.
- `done`  out  1  high in state DONE.
- `err_code`  out  2  error code: 0 none, 1 bad ID, 2 operand out of range, 3 memory full.
- `count`  out  ADDR_W+1  number of words written in the current session.

## Operation
- **FSM states:** IDLE, LOAD, DONE, ERR. Reset state is IDLE.
- **Transitions:**
  - `start` from any state goes to LOAD and clears `count` and `err_code`. `start` has priority over a same-cycle handshake.
  - In LOAD, an accepted instruction with `in_last=1` and no error goes to DONE.
  - In LOAD, an accepted instruction with an error goes to ERR.
- `in_ready` = (state == LOAD). An accept happens when `in_valid & in_ready`.
- **Encoding.** Register fields use `in_x[4:0]`. The immediate is `in_rt[15:0]`. Unused bits are 0.
  - ID 1–4: opcode 0, [25:21]=rs, [20:16]=rt, [15:11]=rd, shamt 0, func = ID−1.
  - ID 7, 8, 24: opcode 3, 4, 19 respectively; R layout as above; func 0.
  - ID 5, 6, 9, 10: opcode = ID−4. ID 13–20 and 25: opcode = ID−5. Layout: [25:21]=rs, [20:16]=rd, [15:0]=imm.
  - ID 11, 12: opcode 7, [25:21]=rs, [20:16]=rd, [10:6]=`in_rt[4:0]`, [5:0] = ID−11. Shift amounts above 31 raise error 2.
  - ID 21–23: opcode = ID−5, [25:0]=`in_rs[25:0]`.
  - ID 26: opcode 21, [25:0]=0.
- **Error checks**, evaluated at accept:
  - Code 1: ID is 0 or greater than 26.
  - Code 2 is raised when any of these holds:
    - a register operand has bits [31:5] nonzero;
    - an immediate is not sign-representable in 16 bits (`in_rt[31:15]` not all equal);
    - a jump target has bits [31:26] nonzero.
  - Code 3: `count == 2^ADDR_W`.
  - Priority when several apply: 3 > 1 > 2.
  - An erroring instruction is not written. ERR holds until `start` or `rst`.
- `in_last` on an erroring instruction is ignored.
- **Address arithmetic:** `mem_addr = BASE_ADDR + count`, modulo 2^ADDR_W. `count` saturates at 2^ADDR_W.

## Timing
- **Reset values:** all outputs 0 (`in_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `done`, `err_code`, `count`); state IDLE. Reset mid-session drops the session immediately and discards any pending write.
- **Write latency:** an accept at edge N produces `mem_we=1` with registered `mem_addr`/`mem_wdata` during cycle N→N+1. `count` increments at edge N.
- **Throughput:** one word per cycle with `in_valid` held high.
- `mem_we` is never high for two cycles on the same address. `mem_wdata` holds its last value when `mem_we=0`.
- **Last instruction:** accept with `in_last` at edge N makes `in_ready` low and `done` high from edge N onward. The final `mem_we` pulse is in the same cycle.
- **Error:** accept at edge N sets `err_code` and ERR at edge N; `mem_we` stays 0.
- `start` during LOAD or DONE restarts at `BASE_ADDR`. An in-flight write pulse still completes.

## Test plan
- **Single R-type.** `start`, then ID 1, rs=1, rt=2, rd=3, `in_last=0` → write `0x00221800` @0, `count`=1.
- **Burst with last.** After `start`, send back-to-back, with `in_last` on the third:
  - ID 5, rs=4, rt=0xFFFFFFFF, rd=5;
  - ID 11, rs=1, rt=10, rd=2;
  - ID 21, rs=100.

  → writes `0x0485FFFF` @0, `0x1C220280` @1, `0x40000064` @2 on consecutive cycles; `done`=1, `count`=3, `in_ready`=0.
- **Bad ID.** ID 27 → `err_code`=1, no `mem_we`, `in_ready`=0. Then `start` → `err_code`=0, `in_ready`=1.
- **Operand out of range.** ID 5 with rt=0x00010000 → `err_code`=2. ID 1 with rd=32 → `err_code`=2.
- **Overflow.** With ADDR_W=2, 5 valid instructions → 4 writes @0–3, then `err_code`=3 and `count`=4.
- **Reset mid-burst.** Assert `rst` asynchronously mid-burst → all outputs 0 before the next edge; after release, `in_ready`=0 until `start`.
